pong_frame_engine: RTL

PONG_FRAME_ENGINE -- requirements
Module: pong_frame_engine

---
 rtl/pong_frame_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pong_frame_engine.sv
// pong_frame_engine
//   Frame sequencer for a simple two-player Pong game. Each frame waits
//   FRAME_TICKS enabled clocks. It then erases the ball and both paddles,
//   updates the game state in a single clock, and redraws the ball and
//   paddles. Shapes are emitted one pixel per clock, in raster order
//   within each rectangle.
//
// Ports
//   clock, reset            system clock; asynchronous active-high reset
//   enable                  allows the WAIT countdown to run
//   sensor_1, sensor_2      raw paddle readings (left, right)
//   ball_colour             colour used to draw the ball
//   paddle_colour           colour used to draw both paddles
//   x_out, y_out            registered pixel coordinate
//   colour_out              registered pixel colour
//   plot                    pixel write strobe
//   frame_done              pulse that coincides with the last pixel of a frame
//   score_1, score_2        saturating player scores
//
// Pixel handshake: plot is a strobe with no back-pressure. x_out, y_out
// and colour_out are valid only in a cycle where plot=1. They hold their
// values in every other cycle.
module pong_frame_engine #(
    parameter int COORD_W      = 10,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int BALL_SIZE    = 4,
    parameter int PADDLE_W     = 4,
    parameter int PADDLE_H     = 16,
    parameter int FRAME_TICKS  = 833333,
    parameter int SENSOR_MAX   = 40,
    parameter int SENSOR_SCALE = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [COORD_W-1:0] sensor_1,
    input  logic [COORD_W-1:0] sensor_2,
    input  logic [2:0]         ball_colour,
    input  logic [2:0]         paddle_colour,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [2:0]         colour_out,
    output logic               plot,
    output logic               frame_done,
    output logic [3:0]         score_1,
    output logic [3:0]         score_2
);

    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int PW    = 2 * COORD_W;  // headroom for the sensor product and overlap sums

    localparam logic [CNT_W-1:0]   RELOAD  = CNT_W'(FRAME_TICKS - 1);
    localparam logic [COORD_W-1:0] BS      = COORD_W'(BALL_SIZE);
    localparam logic [COORD_W-1:0] PDW     = COORD_W'(PADDLE_W);
    localparam logic [COORD_W-1:0] PDH     = COORD_W'(PADDLE_H);
    localparam logic [COORD_W-1:0] CX      = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] CY      = COORD_W'(SCREEN_H / 2);
    localparam logic [COORD_W-1:0] P_INIT  = COORD_W'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [COORD_W-1:0] P2_X    = COORD_W'(SCREEN_W - PADDLE_W);
    localparam logic [COORD_W-1:0] BY_MAX  = COORD_W'(SCREEN_H - BALL_SIZE);
    localparam logic [COORD_W-1:0] BX_MAX  = COORD_W'(SCREEN_W - BALL_SIZE);
    localparam logic [COORD_W-1:0] HIT_R   = COORD_W'(SCREEN_W - PADDLE_W - BALL_SIZE);
    localparam logic [PW-1:0]      PY_MAX  = PW'(SCREEN_H - PADDLE_H);

    typedef enum logic [2:0] {
        S_WAIT, S_ERASE_B, S_ERASE_P1, S_ERASE_P2,
        S_UPDATE, S_DRAW_B, S_DRAW_P1, S_DRAW_P2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [COORD_W-1:0] kx, ky;          // column and row inside the current rectangle
    logic [COORD_W-1:0] bx, by, p1y, p2y;
    logic               dir_x, dir_y;    // 1 = right / down

    // Rectangle currently being emitted.
    logic [COORD_W-1:0] w, h, ox, oy;
    logic               emitting, last, erasing;
    logic [2:0]         pix_colour;

    always_comb begin
        w = BS; h = BS; ox = bx; oy = by;
        emitting   = 1'b1;
        erasing    = 1'b0;
        pix_colour = ball_colour;
        case (state)
            S_ERASE_B:  begin erasing = 1'b1; end
            S_ERASE_P1: begin erasing = 1'b1; w = PDW; h = PDH; ox = '0; oy = p1y; end
            S_ERASE_P2: begin erasing = 1'b1; w = PDW; h = PDH; ox = P2_X; oy = p2y; end
            S_DRAW_B:   begin end
            S_DRAW_P1:  begin w = PDW; h = PDH; ox = '0; oy = p1y; pix_colour = paddle_colour; end
            S_DRAW_P2:  begin w = PDW; h = PDH; ox = P2_X; oy = p2y; pix_colour = paddle_colour; end
            default:    begin emitting = 1'b0; end
        endcase
        if (erasing) pix_colour = 3'b000;
        last = emitting && (kx == w - 1'b1) && (ky == h - 1'b1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:     if (enable && cnt == '0) state_nxt = S_ERASE_B;
            S_ERASE_B:  if (last) state_nxt = S_ERASE_P1;
            S_ERASE_P1: if (last) state_nxt = S_ERASE_P2;
            S_ERASE_P2: if (last) state_nxt = S_UPDATE;
            S_UPDATE:   state_nxt = S_DRAW_B;
            S_DRAW_B:   if (last) state_nxt = S_DRAW_P1;
            S_DRAW_P1:  if (last) state_nxt = S_DRAW_P2;
            S_DRAW_P2:  if (last) state_nxt = S_WAIT;
            default:    state_nxt = S_WAIT;
        endcase
    end

    // Game-state update. Collisions read the paddle positions from before this update.
    logic [PW-1:0]      prod1, prod2;
    logic [COORD_W-1:0] p1y_nxt, p2y_nxt, bx_nxt, by_nxt;
    logic               dx_nxt, dy_nxt, hit_l, hit_r, miss_l, miss_r;
    logic [3:0]         s1_nxt, s2_nxt;

    always_comb begin
        prod1 = PW'(sensor_1) * PW'(SENSOR_SCALE);
        prod2 = PW'(sensor_2) * PW'(SENSOR_SCALE);
        p1y_nxt = p1y;
        p2y_nxt = p2y;
        if (PW'(sensor_1) < PW'(SENSOR_MAX))
            p1y_nxt = (prod1 > PY_MAX) ? COORD_W'(PY_MAX) : COORD_W'(prod1);
        if (PW'(sensor_2) < PW'(SENSOR_MAX))
            p2y_nxt = (prod2 > PY_MAX) ? COORD_W'(PY_MAX) : COORD_W'(prod2);

        hit_l  = (bx == PDW) && !dir_x &&
                 (PW'(by) + PW'(BS) > PW'(p1y)) && (PW'(by) < PW'(p1y) + PW'(PDH));
        hit_r  = (bx == HIT_R) && dir_x &&
                 (PW'(by) + PW'(BS) > PW'(p2y)) && (PW'(by) < PW'(p2y) + PW'(PDH));
        miss_l = (bx == '0) && !dir_x;
        miss_r = (bx == BX_MAX) && dir_x;

        s1_nxt = score_1;
        s2_nxt = score_2;
        if (miss_l || miss_r) begin
            // A miss respawns the ball and takes priority over any Y reflection.
            bx_nxt = CX;
            by_nxt = CY;
            dx_nxt = miss_l;
            dy_nxt = 1'b1;
            if (miss_l && score_2 != 4'd15) s2_nxt = score_2 + 4'd1;
            if (miss_r && score_1 != 4'd15) s1_nxt = score_1 + 4'd1;
        end else begin
            dy_nxt = dir_y;
            if (by == '0 && !dir_y)    dy_nxt = 1'b1;
            if (by == BY_MAX && dir_y) dy_nxt = 1'b0;
            dx_nxt = dir_x;
            if (hit_l) dx_nxt = 1'b1;
            if (hit_r) dx_nxt = 1'b0;
            by_nxt = dy_nxt ? by + 1'b1 : by - 1'b1;
            bx_nxt = dx_nxt ? bx + 1'b1 : bx - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_WAIT;
            cnt        <= RELOAD;
            kx         <= '0;
            ky         <= '0;
            bx         <= CX;
            by         <= CY;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            p1y        <= P_INIT;
            p2y        <= P_INIT;
            score_1    <= '0;
            score_2    <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && enable)
                cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;

            if (!emitting || last) begin
                kx <= '0;
                ky <= '0;
            end else if (kx == w - 1'b1) begin
                kx <= '0;
                ky <= ky + 1'b1;
            end else begin
                kx <= kx + 1'b1;
            end

            plot       <= emitting;
            frame_done <= (state == S_DRAW_P2) && last;
            if (emitting) begin
                x_out      <= ox + kx;
                y_out      <= oy + ky;
                colour_out <= pix_colour;
            end

            if (state == S_UPDATE) begin
                bx      <= bx_nxt;
                by      <= by_nxt;
                dir_x   <= dx_nxt;
                dir_y   <= dy_nxt;
                p1y     <= p1y_nxt;
                p2y     <= p2y_nxt;
                score_1 <= s1_nxt;
                score_2 <= s2_nxt;
            end
        end
    end

endmodule
